// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline defines: stage indices and the default stage count.
package pipe_hazard_ctrl_pkg;

  localparam int NSTAGE  = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EXE = 3;
  localparam int STG_MEM = 4;

endpackage

// File: rtl/pipe_mc_cnt.sv
// Multi-cycle operation down-counter: busy while non-zero, done on the last busy cycle.
module pipe_mc_cnt #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] cycles_i,
  output logic         busy_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Count down while active; load only when idle and the op actually spans extra cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
    else if (start_i && (cycles_i > W'(1)))
      cnt_d = cycles_i - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall thermometer, flush/redirect with one pending slot,
// multi-cycle stall source and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int NSTAGE      = pipe_hazard_ctrl_pkg::NSTAGE,
  parameter int ADDR_WIDTH  = 32,
  parameter int MC_STAGE    = 2,
  parameter int FLUSH_STAGE = 2,
  parameter int MC_CNT_W    = 6,
  parameter int PERF_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NSTAGE-1:0]     stallreq_i,
  input  logic                  flush_req_i,
  input  logic [ADDR_WIDTH-1:0] flush_addr_i,
  input  logic                  mc_start_i,
  input  logic [MC_CNT_W-1:0]   mc_cycles_i,
  output logic [NSTAGE-1:0]     stall_o,
  output logic [NSTAGE-1:0]     flush_o,
  output logic [ADDR_WIDTH-1:0] new_pc_o,
  output logic                  new_pc_valid_o,
  output logic                  mc_busy_o,
  output logic                  mc_done_o,
  output logic [PERF_W-1:0]     stall_cycles_o
);
  import pipe_hazard_ctrl_pkg::*;

  function automatic logic [NSTAGE-1:0] range_mask(int lo, int hi);
    logic [NSTAGE-1:0] m;
    m = '0;
    for (int i = 0; i < NSTAGE; i++)
      if (i >= lo && i <= hi) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [NSTAGE-1:0] FLUSH_MASK = range_mask(STG_IF, FLUSH_STAGE);
  localparam logic [NSTAGE-1:0] YOUNG_MASK = range_mask(STG_PC, FLUSH_STAGE - 1);
  localparam logic [NSTAGE-1:0] HOLD_MASK  = range_mask(FLUSH_STAGE, NSTAGE - 1);

  logic                  mc_busy, mc_done;
  logic [NSTAGE-1:0]     req, stall_raw, stall_int, flush_int;
  logic                  issuable, issue_pend, issue_new, issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [PERF_W-1:0]     perf_q, perf_d;

  pipe_mc_cnt #(.W(MC_CNT_W)) u_mc_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mc_start_i),
    .cycles_i (mc_cycles_i),
    .busy_o   (mc_busy),
    .done_o   (mc_done)
  );

  assign req = stallreq_i | ({{(NSTAGE-1){1'b0}}, mc_busy} << MC_STAGE);

  // Freeze every stage at or below the highest requesting stage.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    stall_raw = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc          = acc | req[i];
      stall_raw[i] = acc;
    end
  end

  // An older pending redirect always wins over a fresh request.
  always_comb begin
    issuable    = ((req & HOLD_MASK) == '0);
    issue_pend  = pend_q & issuable;
    issue_new   = ~pend_q & flush_req_i & issuable;
    issue       = issue_pend | issue_new;
    issue_addr  = pend_q ? pend_addr_q : flush_addr_i;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (issue_pend) begin
      pend_d = 1'b0;
    end else if (!pend_q && flush_req_i && !issuable) begin
      pend_d      = 1'b1;
      pend_addr_d = flush_addr_i;
    end
    flush_int = issue ? FLUSH_MASK : '0;
    stall_int = issue ? (stall_raw & ~YOUNG_MASK) : stall_raw;
  end

  // Stall-cycle counter saturates rather than wrapping.
  always_comb begin
    perf_d = perf_q;
    if ((stall_int != '0) && (perf_q != '1)) perf_d = perf_q + 1'b1;
  end

  // Pending redirect and performance state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      perf_q      <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      perf_q      <= perf_d;
    end
  end

  // Combinational paths are masked so reset silences every output immediately.
  always_comb begin
    stall_o        = rst_i ? stall_int : '0;
    flush_o        = rst_i ? flush_int : '0;
    new_pc_valid_o = rst_i & issue;
    new_pc_o       = (rst_i && issue) ? issue_addr : '0;
    mc_busy_o      = rst_i & mc_busy;
    mc_done_o      = rst_i & mc_done;
    stall_cycles_o = perf_q;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter NSTAGE, default 6, giving the number of stall/flush bits (bit0 = pc, bit1 = if_id, bit2 = id_exe, bit3 = exe_mem, bit4 = mem_wb, bit5 = spare).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the redirect address width.
REQ-003 The block SHALL have parameter MC_STAGE, default 2, giving the stage index that the internal multi-cycle stall is raised against.
REQ-004 The block SHALL have parameter FLUSH_STAGE, default 2, giving the highest stage index cleared by a flush.
REQ-005 The block SHALL have parameter MC_CNT_W, default 6, giving the multi-cycle counter width.
REQ-006 The block SHALL have parameter PERF_W, default 32, giving the stall performance counter width.
REQ-007 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_i  in  1  reset, asynchronous, active-low.
REQ-009 stallreq_i  in  NSTAGE  per-stage stall request; bit k requests a freeze of stages 0..k.
REQ-010 flush_req_i  in  1  branch/jump redirect request from stage FLUSH_STAGE.
REQ-011 flush_addr_i  in  ADDR_WIDTH  redirect target; valid with flush_req_i.
REQ-012 mc_start_i  in  1  start of a multi-cycle operation (e.g. divide).
REQ-013 mc_cycles_i  in  MC_CNT_W  total latency of that operation; valid with mc_start_i.
REQ-014 stall_o  out  NSTAGE  per-stage freeze vector.
REQ-015 flush_o  out  NSTAGE  per-stage bubble-insert vector.
REQ-016 new_pc_o  out  ADDR_WIDTH  redirect target to pc_reg.
REQ-017 new_pc_valid_o  out  1  redirect strobe.
REQ-018 mc_busy_o  out  1  multi-cycle operation in progress.
REQ-019 mc_done_o  out  1  one-cycle pulse on the last busy cycle.
REQ-020 stall_cycles_o  out  PERF_W  count of stalled cycles.

Function
REQ-021 The effective request vector SHALL be req = stallreq_i OR (mc_busy_o shifted to bit MC_STAGE).
REQ-022 stall_o SHALL be combinational: with k the highest set bit of req, stall_o[k:0] = all ones and the upper bits 0; stall_o = 0 when req = 0.
REQ-023 The multi-cycle counter SHALL load mc_cycles_i-1 when mc_start_i=1 and it is idle (count 0); mc_busy_o SHALL be 1 while count != 0.
REQ-024 The multi-cycle counter SHALL decrement by 1 per cycle while non-zero.
REQ-025 mc_cycles_i of 0 or 1 SHALL cause no busy cycles and no mc_done_o pulse.
REQ-026 mc_start_i SHALL be ignored while mc_busy_o=1.
REQ-027 mc_done_o SHALL be 1 exactly in the cycle where count = 1.
REQ-028 A flush SHALL be issuable when no bit of req at index >= FLUSH_STAGE is set.
REQ-029 If a flush is issuable when flush_req_i=1, the block SHALL issue it in the same cycle.
REQ-030 If a flush is not issuable when flush_req_i=1, the block SHALL latch flush_addr_i into a pending register and set a pend flag.
REQ-031 A pending flush SHALL be issued in the first cycle it becomes issuable, taking priority over a new flush_req_i in that cycle; the new request SHALL then be dropped.
REQ-032 A flush_req_i arriving while pend=1 SHALL be ignored (older redirect wins).
REQ-033 Issue cycle: flush_o[FLUSH_STAGE:1] = 1 and all other flush_o bits 0; new_pc_valid_o = 1; new_pc_o = the issued address; pend cleared.
REQ-034 Issue cycle: stall_o[FLUSH_STAGE-1:0] SHALL be forced to 0 (flush overrides younger-stage stalls); higher stall_o bits are unaffected.
REQ-035 When no flush is issued, flush_o = 0, new_pc_valid_o = 0 and new_pc_o = 0.
REQ-036 A flush SHALL NOT abort an active multi-cycle operation.
REQ-037 stall_cycles_o SHALL increment in each cycle with stall_o != 0.
REQ-038 stall_cycles_o SHALL saturate at all-ones.

Reset
REQ-039 rst_i=0 SHALL asynchronously clear: counter, pend flag, pending address and stall_cycles_o.
REQ-040 While rst_i=0 all outputs SHALL be 0, including during an in-flight multi-cycle operation or pending flush.
REQ-041 Operation SHALL resume from idle on the first edge after release.

Structure
REQ-042 Stage index constants (STG_PC, STG_IF, STG_ID, STG_EXE, STG_MEM) and NSTAGE SHALL live in the shared defines package.
REQ-043 The multi-cycle down-counter SHALL be a sub-module, pipe_mc_cnt.
REQ-044 pipe_hazard_ctrl SHALL replace pipe_ctrl in test_top.

Verification
REQ-045 The bench SHALL cover: stallreq_i=6'b000100 -> stall_o=6'b000111; stallreq_i=6'b010010 -> stall_o=6'b011111; stallreq_i=0 -> stall_o=0.
REQ-046 The bench SHALL cover: mc_start_i=1, mc_cycles_i=4 at cycle 0 -> mc_busy_o=1 for cycles 1-3, mc_done_o=1 at cycle 3, stall_o=6'b000111 for cycles 1-3; a second mc_start_i at cycle 2 is ignored; mc_cycles_i=1 -> no busy.
REQ-047 The bench SHALL cover: flush_req_i=1, flush_addr_i=0x80, no stall -> same cycle flush_o=6'b000110, new_pc_valid_o=1, new_pc_o=0x80, stall_o[1:0]=0.
REQ-048 The bench SHALL cover: flush_req_i at 0x100 while stallreq_i[3]=1 for 3 cycles, then flush_req_i at 0x200 one cycle later -> a single redirect to 0x100 in the cycle stallreq_i[3] drops; 0x200 is never issued.
REQ-049 The bench SHALL cover: rst_i pulled low mid multi-cycle operation with a flush pending -> all outputs 0 immediately; after release no flush is issued and mc_busy_o=0.
REQ-050 The bench SHALL cover: PERF_W=4 with a stall held 20 cycles -> stall_cycles_o saturates at 15.
